j1_io_responder: RTL and testbench

- Responder end of the J1 core's I/O bus: decodes the core's io_wr / mem_addr / dout strobes and returns io_din.
- Hosts a GPIO output register, a synchronised GPIO input, a free-running tick counter and a FIFO-buffered 8N1 UART transmitter.
- Sits beside the core at SoC top level. The core's memory port goes elsewhere; only the I/O space lands here.

---
 rtl/j1_io_responder.sv | 191 +++++++++++++++++++
 tb/tb_j1_io_responder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/j1_io_responder.sv
// J1 I/O-space responder: GPIO out/in, tick counter and FIFO-buffered 8N1 UART TX.
// Define J1_IO_TICKS_EN to build the TICKS counter; otherwise TICKS reads 0.
`ifndef WIDTH
`define WIDTH 16
`endif

module j1_io_responder #(
   parameter int CLKS_PER_BIT = 217,
   parameter int FIFO_DEPTH   = 4,
   parameter int GPIO_W       = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                io_wr,
   input  logic [15:0]         mem_addr,
   input  logic [`WIDTH-1:0]   dout,
   output logic [`WIDTH-1:0]   io_din,
   output logic [GPIO_W-1:0]   gpio_out,
   input  logic [GPIO_W-1:0]   gpio_in,
   output logic                uart_tx
);

   localparam int W     = `WIDTH;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CNT_W = AW + 1;
   localparam int BW    = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [15:0]       addr_q;
   logic [GPIO_W-1:0] gpio_s1, gpio_s2;
   logic [7:0]        fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic              full, busy, push_req, push, pop;
   state_t            state;
   logic [BW-1:0]     baud;
   logic [2:0]        bit_idx;
   logic [7:0]        shreg;
   logic              baud_end;
   logic [2:0]        stat;
   logic [W-1:0]      ticks_rd;
   logic              unused_bits;

   // The core presents the address one cycle early; everything decodes on addr_q.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q  <= '0;
         gpio_s1 <= '0;
         gpio_s2 <= '0;
      end else begin
         addr_q  <= mem_addr;
         gpio_s1 <= gpio_in;
         gpio_s2 <= gpio_s1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gpio_out <= '0;
      end else if (io_wr && addr_q[0]) begin
         gpio_out <= dout[GPIO_W-1:0];
      end
   end

   assign full     = (count == CNT_W'(FIFO_DEPTH));
   assign push_req = io_wr & addr_q[12];
   assign push     = push_req & ~full;
   assign pop      = (state == IDLE) && (count != '0);
   assign busy     = (count != '0) || (state != IDLE);
   assign stat     = {overflow, busy, full};

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= dout[7:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
         // A dropped push in the same cycle as a STAT write leaves overflow set.
         if (io_wr && addr_q[13]) overflow <= 1'b0;
         if (push_req && full)    overflow <= 1'b1;
      end
   end

   assign baud_end = (baud == BW'(CLKS_PER_BIT - 1));

   // uart_tx is registered and changes on the same edge as the state it belongs to.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         uart_tx <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  shreg   <= fifo_mem[rd_ptr];
                  state   <= START;
                  baud    <= '0;
                  uart_tx <= 1'b0;
               end
            end
            START: begin
               if (baud_end) begin
                  state   <= DATA;
                  baud    <= '0;
                  bit_idx <= '0;
                  uart_tx <= shreg[0];
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            DATA: begin
               if (baud_end) begin
                  baud <= '0;
                  if (bit_idx == 3'd7) begin
                     state   <= STOP;
                     uart_tx <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     uart_tx <= shreg[1];
                     shreg   <= {1'b0, shreg[7:1]};
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            STOP: begin
               if (baud_end) begin
                  state <= IDLE;
                  baud  <= '0;
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               baud    <= '0;
               uart_tx <= 1'b1;
            end
         endcase
      end
   end

`ifdef J1_IO_TICKS_EN
   logic [W-1:0] ticks;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ticks <= '0;
      end else if (io_wr && addr_q[14]) begin
         ticks <= dout;
      end else begin
         ticks <= ticks + 1'b1;
      end
   end

   assign ticks_rd = addr_q[14] ? ticks : '0;
`else
   assign ticks_rd = '0;
`endif

   // Multiple select bits read back as the OR of every selected source.
   always_comb begin
      io_din = '0;
      if (addr_q[0])  io_din = io_din | W'(gpio_out);
      if (addr_q[1])  io_din = io_din | W'(gpio_s2);
      if (addr_q[13]) io_din = io_din | W'(stat);
      io_din = io_din | ticks_rd;
   end

   assign unused_bits = ^{addr_q[15], addr_q[11:2], dout};

endmodule

// File: tb/tb_j1_io_responder.sv
// Randomised scoreboard bench for j1_io_responder against a frame-level reference model.
`ifndef WIDTH
`define WIDTH 16
`endif

module tb_j1_io_responder;
   localparam int C = 4;
   localparam int D = 4;
   localparam int G = 8;
   localparam int W = `WIDTH;

   logic          clk = 1'b0;
   logic          reset;
   logic          io_wr;
   logic [15:0]   mem_addr;
   logic [W-1:0]  dout;
   logic [W-1:0]  io_din;
   logic [G-1:0]  gpio_out;
   logic [G-1:0]  gpio_in;
   logic          uart_tx;

   always #5 clk = ~clk;

   j1_io_responder #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .GPIO_W(G)) dut (
      .clk(clk), .reset(reset), .io_wr(io_wr), .mem_addr(mem_addr), .dout(dout),
      .io_din(io_din), .gpio_out(gpio_out), .gpio_in(gpio_in), .uart_tx(uart_tx)
   );

   typedef struct { logic [7:0] b; bit b2b; } frame_t;

   int checks = 0;
   int failures = 0;

   // reference model state
   logic [7:0]   fifo_q[$];
   frame_t       exp_uart[$];
   logic [W-1:0] exp_rd[$];
   bit           idle_m, just_idle, ovf_m;
   int           busy_left;
   logic [G-1:0] gpio_m, g1, g2;
   logic [W-1:0] ticks_m;
   logic [15:0]  aq_m;

   logic         rd_chk;
   int           cyc = 0, last_end = -100, mon_k = 0, frames_seen = 0;
   bit           mon_act = 0, mon_glitch = 0;
   logic [7:0]   mon_byte;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      fifo_q.delete();
      exp_uart.delete();
      idle_m = 1; just_idle = 0; ovf_m = 0; busy_left = 0;
      gpio_m = '0; g1 = '0; g2 = '0; ticks_m = '0; aq_m = '0;
   endtask

   // Frame-level view: a popped byte occupies the line for 10*C cycles.
   task automatic model_edge();
      logic [15:0] a;
      bit pop, preq, acc;
      frame_t f;
      a    = aq_m;
      pop  = idle_m && (fifo_q.size() != 0);
      preq = io_wr && a[12];
      acc  = preq && (fifo_q.size() < D);
      if (pop) begin
         f.b = fifo_q.pop_front();
         f.b2b = just_idle;
         exp_uart.push_back(f);
         idle_m = 0; busy_left = 10 * C; just_idle = 0;
      end else if (!idle_m) begin
         busy_left--;
         if (busy_left == 0) begin idle_m = 1; just_idle = 1; end
      end else begin
         just_idle = 0;
      end
      if (acc) fifo_q.push_back(dout[7:0]);
      if (io_wr && a[13]) ovf_m = 0;
      if (preq && !acc) ovf_m = 1;
      if (io_wr && a[0]) gpio_m = dout[G-1:0];
      if (io_wr && a[14]) ticks_m = dout; else ticks_m = ticks_m + 1'b1;
      g2 = g1; g1 = gpio_in; aq_m = mem_addr;
   endtask

   function automatic logic [W-1:0] model_read(input logic [15:0] a);
      logic [W-1:0] r;
      bit bz, fl;
      r  = '0;
      bz = (fifo_q.size() != 0) || !idle_m;
      fl = (fifo_q.size() == D);
      if (a[0])  r = r | W'(gpio_m);
      if (a[1])  r = r | W'(g2);
      if (a[13]) r = r | W'({ovf_m, bz, fl});
`ifdef J1_IO_TICKS_EN
      if (a[14]) r = r | ticks_m;
`endif
      return r;
   endfunction

   initial begin
      model_clear();
      forever begin
         @(posedge clk or posedge reset);
         if (reset) model_clear(); else model_edge();
      end
   end

   // Monitor: register reads and UART frames, sampled on the falling edge.
   initial begin
      frame_t f;
      int b;
      forever begin
         @(negedge clk);
         cyc++;
         if (rd_chk) begin
            check("rd_queue", 32'(exp_rd.size() != 0), 1);
            if (exp_rd.size() != 0) check("io_din", io_din, exp_rd.pop_front());
            check("gpio_out", gpio_out, gpio_m);
         end
         if (reset) begin
            mon_act = 0;
         end else begin
            if (!mon_act && uart_tx == 1'b0) begin
               mon_act = 1; mon_k = 0; mon_glitch = 0; mon_byte = '0;
               if (exp_uart.size() != 0 && exp_uart[0].b2b) check("uart_idle_gap", cyc - last_end - 1, 1);
            end
            if (mon_act) begin
               b = mon_k / C;
               if (b == 0) begin
                  if (uart_tx !== 1'b0) mon_glitch = 1;
               end else if (b <= 8) begin
                  if (mon_k % C == 0) mon_byte[b-1] = uart_tx;
                  else if (uart_tx !== mon_byte[b-1]) mon_glitch = 1;
               end else if (uart_tx !== 1'b1) begin
                  mon_glitch = 1;
               end
               if (mon_k == 10 * C - 1) begin
                  mon_act = 0; last_end = cyc; frames_seen++;
                  check("uart_shape", 32'(mon_glitch), 0);
                  check("uart_expected", 32'(exp_uart.size() != 0), 1);
                  if (exp_uart.size() != 0) begin
                     f = exp_uart.pop_front();
                     check("uart_byte", mon_byte, f.b);
                  end
               end else begin
                  mon_k++;
               end
            end
         end
      end
   end

   task automatic step(input logic [15:0] a, input logic w, input logic [W-1:0] d, input logic chk);
      @(posedge clk); #1;
      mem_addr = a; io_wr = w; dout = d; rd_chk = chk;
      if (chk) exp_rd.push_back(model_read(aq_m));
   endtask

   task automatic drain(input int max_cyc);
      bit done;
      done = 0;
      for (int i = 0; i < max_cyc && !done; i++) begin
         step(16'h2000, 1'b0, '0, 1'b1);
         done = idle_m && fifo_q.size() == 0 && exp_uart.size() == 0 && !mon_act;
      end
      check("drain_done", 32'(done), 1);
   endtask

   initial begin
      #2_000_000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   logic [15:0] addr_tab [12] = '{16'h0001, 16'h0002, 16'h1000, 16'h2000, 16'h4000, 16'h0003,
                                  16'h4001, 16'h3000, 16'h0000, 16'h0100, 16'h8000, 16'h1001};
   logic [W-1:0] tick_exp [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

   initial begin
      int fs0;
      reset = 1; io_wr = 0; mem_addr = '0; dout = '0; gpio_in = '0; rd_chk = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_uart_tx", uart_tx, 1);
      check("rst_gpio_out", gpio_out, 0);
      check("rst_io_din", io_din, 0);
      reset = 0;
      step(16'h6003, 0, '0, 1);
      step(16'h0000, 0, '0, 1);
      step(16'h0000, 0, '0, 1);

      // GPIO write and readback
      step(16'h0001, 0, '0, 1);
      step(16'h0001, 1, 16'h00A5, 1);
      step(16'h0001, 0, '0, 1);
      check("gpio_a5_out", gpio_out, 8'hA5);
      check("gpio_a5_din", io_din, 16'h00A5);

      // GPIO input synchroniser
      step(16'h0002, 0, '0, 1);
      gpio_in = 8'h3C;
      repeat (3) step(16'h0002, 0, '0, 1);
      check("gpio_in_3c", io_din, 16'h003C);

      // single UART frame
      step(16'h1000, 0, '0, 1);
      step(16'h2000, 1, 16'h0055, 1);
      drain(100);
      check("stat_after_frame", io_din, 0);

      // FIFO full and overflow
      fs0 = frames_seen;
      step(16'h1000, 0, '0, 1);
      for (int i = 0; i < 5; i++) step(16'h1000, 1, W'(16'h10 + i), 1);
      step(16'h2000, 1, 16'h0015, 1);
      step(16'h2000, 0, '0, 1);
      check("stat_full_ovf", io_din, 16'h0007);
      step(16'h2000, 1, '0, 1);
      step(16'h2000, 0, '0, 1);
      check("ovf_cleared", io_din & 16'h0004, 0);
      drain(600);
      check("frames_emitted", frames_seen - fs0, 5);

      // TICKS load and wrap
      step(16'h4000, 0, '0, 1);
      step(16'h4000, 1, 16'hFFFE, 1);
      for (int i = 0; i < 4; i++) begin
         step(16'h4000, 0, '0, 1);
`ifdef J1_IO_TICKS_EN
         check("ticks_seq", io_din, tick_exp[i]);
`else
         check("ticks_absent", io_din, 0);
`endif
      end

      // randomised traffic
      for (int i = 0; i < 400; i++) begin
         step(addr_tab[$urandom_range(0, 11)], ($urandom_range(0, 3) == 0), W'($urandom), 1);
         if ($urandom_range(0, 7) == 0) gpio_in = G'($urandom);
      end
      step(16'h0000, 0, '0, 1);
      drain(600);

      // asynchronous reset in the middle of a frame
      step(16'h0001, 0, '0, 0);
      step(16'h0001, 1, 16'h005A, 0);
      step(16'h1000, 0, '0, 1);
      step(16'h2000, 1, 16'h00A3, 1);
      repeat (10) step(16'h0000, 0, '0, 0);
      @(posedge clk);
      #3;
      reset = 1;
      #1;
      check("arst_uart_tx", uart_tx, 1);
      check("arst_gpio_out", gpio_out, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      step(16'h2000, 0, '0, 0);
      for (int i = 0; i < 60; i++) begin
         step(16'h2000, 0, '0, 1);
         check("post_rst_line", uart_tx, 1);
      end
      check("post_rst_stat", io_din, 0);
      step(16'h0000, 0, '0, 0);
      step(16'h0000, 0, '0, 0);
      check("uart_leftover", exp_uart.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
